// File: rtl/led_shifter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : led_shifter_pkg                                      |
// | Description : Shared widths, state encoding, mode codes, init      |
// |               patterns and small helpers for the LED shifter.      |
// |               Macro LED_SHIFTER_BOUNCE_EN adds the S_BOUNCE state. |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
package led_shifter_pkg;

   localparam int LED_W = 16;

   localparam logic [1:0] MODE_SHIFT  = 2'b00;
   localparam logic [1:0] MODE_FILL   = 2'b01;
   localparam logic [1:0] MODE_FLASH  = 2'b10;
   localparam logic [1:0] MODE_BOUNCE = 2'b11;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   localparam logic [LED_W-1:0] INIT_SHIFT  = 16'h0001;
   localparam logic [LED_W-1:0] INIT_FILL   = 16'h0000;
   localparam logic [LED_W-1:0] INIT_FLASH  = 16'h0000;
   localparam logic [LED_W-1:0] INIT_BOUNCE = 16'h0001;
   localparam logic [LED_W-1:0] LED_ONE     = 16'h0001;
   localparam logic [LED_W-1:0] LED_ALL     = 16'hFFFF;
   localparam logic [LED_W-1:0] LED_NONE    = 16'h0000;

   // State codes equal the mode codes so a mode change is a direct compare.
`ifdef LED_SHIFTER_BOUNCE_EN
   typedef enum logic [1:0] {
      S_SHIFT  = 2'b00,
      S_FILL   = 2'b01,
      S_FLASH  = 2'b10,
      S_BOUNCE = 2'b11
   } state_t;
`else
   typedef enum logic [1:0] {
      S_SHIFT  = 2'b00,
      S_FILL   = 2'b01,
      S_FLASH  = 2'b10
   } state_t;
`endif

   // Without the bounce feature, mode 11 is an alias of SHIFT.
   function automatic state_t mode_to_state(input logic [1:0] mode);
      state_t s;
      case (mode)
         MODE_FILL:   s = S_FILL;
         MODE_FLASH:  s = S_FLASH;
`ifdef LED_SHIFTER_BOUNCE_EN
         MODE_BOUNCE: s = S_BOUNCE;
`endif
         default:     s = S_SHIFT;
      endcase
      return s;
   endfunction

   function automatic logic [LED_W-1:0] init_pattern(input state_t s);
      logic [LED_W-1:0] p;
      case (s)
         S_FILL:   p = INIT_FILL;
         S_FLASH:  p = INIT_FLASH;
`ifdef LED_SHIFTER_BOUNCE_EN
         S_BOUNCE: p = INIT_BOUNCE;
`endif
         default:  p = INIT_SHIFT;
      endcase
      return p;
   endfunction

   function automatic logic is_onehot(input logic [LED_W-1:0] v);
      return (v != LED_NONE) && ((v & (v - LED_ONE)) == LED_NONE);
   endfunction

endpackage
`default_nettype wire

// File: rtl/tick_edge_detect.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tick_edge_detect                                     |
// | Description : Turns the divided-clock level "tick" into a one-clk  |
// |               step pulse on its rising edge, sampled on clk.       |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module tick_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   output logic step
);

   logic tick_q;
   // arm_q stays low until tick has been seen low once after reset, so a
   // tick that is already high when reset releases cannot fake an edge.
   logic arm_q;

   // Register tick and arm the detector once tick has been observed low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_q <= 1'b0;
         arm_q  <= 1'b0;
      end else begin
         tick_q <= tick;
         arm_q  <= arm_q | ~tick;
      end
   end

   assign step = tick & ~tick_q & arm_q;

endmodule
`default_nettype wire

// File: rtl/led_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : led_shifter                                          |
// | Description : 16-bit LED pattern generator (SHIFT/FILL/FLASH/      |
// |               BOUNCE) advanced by rising edges of tick.            |
// |               Macro LED_SHIFTER_BOUNCE_EN enables BOUNCE mode;     |
// |               without it mode 11 behaves as SHIFT.                 |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module led_shifter
   import led_shifter_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             en,
   input  logic             dir,
   input  logic [1:0]       mode,
   output logic [LED_W-1:0] led,
   output logic             wrap
);

   logic             step;
   state_t           target;
   state_t           state_q, state_d;
   logic [LED_W-1:0] led_q,   led_d;
   logic             wrap_q,  wrap_d;
`ifdef LED_SHIFTER_BOUNCE_EN
   logic             bdir_q,  bdir_d;
`endif

   tick_edge_detect u_tick_edge_detect (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .step (step)
   );

   assign target = mode_to_state(mode);

   // State, pattern and wrap registers; reset abandons any pattern in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_SHIFT;
         led_q   <= INIT_SHIFT;
         wrap_q  <= 1'b0;
`ifdef LED_SHIFTER_BOUNCE_EN
         bdir_q  <= DIR_LEFT;
`endif
      end else begin
         state_q <= state_d;
         led_q   <= led_d;
         wrap_q  <= wrap_d;
`ifdef LED_SHIFTER_BOUNCE_EN
         bdir_q  <= bdir_d;
`endif
      end
   end

   // Next pattern on an enabled step: reload on mode change, else advance.
   always_comb begin
      state_d = state_q;
      led_d   = led_q;
      wrap_d  = 1'b0;
`ifdef LED_SHIFTER_BOUNCE_EN
      bdir_d  = bdir_q;
`endif
      if (step && en) begin
         if (target != state_q) begin
            state_d = target;
            led_d   = init_pattern(target);
`ifdef LED_SHIFTER_BOUNCE_EN
            bdir_d  = dir;
`endif
         end else begin
            case (state_q)
               S_SHIFT: begin
                  if (!is_onehot(led_q)) begin
                     led_d = INIT_SHIFT;
                  end else if (dir == DIR_LEFT) begin
                     led_d  = {led_q[LED_W-2:0], led_q[LED_W-1]};
                     wrap_d = led_q[LED_W-1];
                  end else begin
                     led_d  = {led_q[0], led_q[LED_W-1:1]};
                     wrap_d = led_q[0];
                  end
               end
               // Any value is a legal FILL pattern: a dir change mid-fill
               // leaves mixed bits that still fill up to all-ones.
               S_FILL: begin
                  if (led_q == LED_ALL) begin
                     led_d  = LED_NONE;
                     wrap_d = 1'b1;
                  end else if (dir == DIR_LEFT) begin
                     led_d = {led_q[LED_W-2:0], 1'b1};
                  end else begin
                     led_d = {1'b1, led_q[LED_W-1:1]};
                  end
               end
               S_FLASH: begin
                  if (led_q == LED_NONE) begin
                     led_d = LED_ALL;
                  end else if (led_q == LED_ALL) begin
                     led_d  = LED_NONE;
                     wrap_d = 1'b1;
                  end else begin
                     led_d = INIT_FLASH;
                  end
               end
`ifdef LED_SHIFTER_BOUNCE_EN
               // dir is ignored here; only the internal bdir steers the bit.
               S_BOUNCE: begin
                  if (!is_onehot(led_q)) begin
                     led_d = INIT_BOUNCE;
                  end else if (bdir_q == DIR_LEFT) begin
                     if (led_q[LED_W-1]) begin
                        led_d  = {1'b0, led_q[LED_W-1:1]};
                        bdir_d = DIR_RIGHT;
                        wrap_d = 1'b1;
                     end else begin
                        led_d = {led_q[LED_W-2:0], 1'b0};
                     end
                  end else begin
                     if (led_q[0]) begin
                        led_d  = {led_q[LED_W-2:0], 1'b0};
                        bdir_d = DIR_LEFT;
                        wrap_d = 1'b1;
                     end else begin
                        led_d = {1'b0, led_q[LED_W-1:1]};
                     end
                  end
               end
`endif
               default: begin
                  state_d = S_SHIFT;
                  led_d   = INIT_SHIFT;
               end
            endcase
         end
      end
   end

   assign led  = led_q;
   assign wrap = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_led_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_led_shifter                                       |
// | Description : Directed, self-checking bench for led_shifter with a |
// |               behavioural model feeding an expected-result queue.  |
// |               Honours LED_SHIFTER_BOUNCE_EN like the design.       |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module tb_led_shifter;

   logic        clk  = 1'b0;
   logic        rst  = 1'b0;
   logic        tick = 1'b0;
   logic        en   = 1'b0;
   logic        dir  = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic [15:0] led;
   logic        wrap;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [15:0] led;
      logic        wrap;
   } exp_t;

   exp_t        sb_q[$];
   logic [15:0] m_led;
   int          m_state;
   logic        m_bdir;
   int          wrap_seen;
   logic [15:0] held;

   always #5 clk = ~clk;

   led_shifter dut (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .en   (en),
      .dir  (dir),
      .mode (mode),
      .led  (led),
      .wrap (wrap)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int map_mode(input logic [1:0] m);
`ifdef LED_SHIFTER_BOUNCE_EN
      return int'(m);
`else
      return (m == 2'b11) ? 0 : int'(m);
`endif
   endfunction

   function automatic void model_reset();
      m_led   = 16'h0001;
      m_state = 0;
      m_bdir  = 1'b0;
      sb_q.delete();
   endfunction

   // Behavioural model of one tick edge; pushes the expected outcome.
   function automatic void model_step();
      exp_t e;
      int   tgt;
      int   v;
      e.wrap = 1'b0;
      if (en) begin
         tgt = map_mode(mode);
         v   = int'(m_led);
         if (tgt != m_state) begin
            m_state = tgt;
            m_led   = (tgt == 1 || tgt == 2) ? 16'h0000 : 16'h0001;
            m_bdir  = dir;
         end else begin
            case (m_state)
               0: begin
                  if ($countones(m_led) != 1) m_led = 16'h0001;
                  else if (!dir) begin
                     e.wrap = (m_led == 16'h8000);
                     m_led  = 16'((v << 1) | (v >> 15));
                  end else begin
                     e.wrap = (m_led == 16'h0001);
                     m_led  = 16'((v >> 1) | (v << 15));
                  end
               end
               1: begin
                  if (m_led == 16'hFFFF) begin
                     m_led  = 16'h0000;
                     e.wrap = 1'b1;
                  end else if (!dir) m_led = 16'((v << 1) | 1);
                  else m_led = 16'((v >> 1) | 32'h8000);
               end
               2: begin
                  if (m_led == 16'h0000) m_led = 16'hFFFF;
                  else begin
                     e.wrap = (m_led == 16'hFFFF);
                     m_led  = 16'h0000;
                  end
               end
               default: begin
                  if ($countones(m_led) != 1) m_led = 16'h0001;
                  else if (!m_bdir) begin
                     if (m_led == 16'h8000) begin
                        m_led = 16'h4000; m_bdir = 1'b1; e.wrap = 1'b1;
                     end else m_led = 16'(v << 1);
                  end else begin
                     if (m_led == 16'h0001) begin
                        m_led = 16'h0002; m_bdir = 1'b0; e.wrap = 1'b1;
                     end else m_led = 16'(v >> 1);
                  end
               end
            endcase
         end
      end
      e.led = m_led;
      sb_q.push_back(e);
   endfunction

   // One tick pulse (high one clk, low one clk); called at a negedge with tick low.
   task automatic pulse(input string tag);
      exp_t e;
      model_step();
      tick = 1'b1;
      @(negedge clk);
      e = sb_q.pop_front();
      chk({tag, " led"}, led, e.led);
      chk({tag, " wrap"}, {15'b0, wrap}, {15'b0, e.wrap});
      if (wrap === 1'b1) wrap_seen++;
      tick = 1'b0;
      @(negedge clk);
      chk({tag, " wrap width"}, {15'b0, wrap}, 16'h0000);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset led", led, 16'h0001);
      chk("reset wrap", {15'b0, wrap}, 16'h0000);
      rst = 1'b1;
      @(negedge clk);

      // Rotate left through all 16 positions.
      en = 1'b1; mode = 2'b00; dir = 1'b0; wrap_seen = 0;
      for (int i = 0; i < 16; i++) pulse("shift_l");
      chk("shift_l final", led, 16'h0001);
      chk("shift_l wrap count", 16'(wrap_seen), 16'd1);

      // Direction change applies immediately.
      dir = 1'b1;
      for (int i = 0; i < 3; i++) pulse("shift_r");
      chk("shift_r final", led, 16'h2000);

      // Fill from the top, then clear with wrap.
      mode = 2'b01; dir = 1'b1;
      for (int i = 0; i < 18; i++) begin
         pulse("fill_r");
         if (i == 16) chk("fill_r full", led, 16'hFFFF);
      end
      chk("fill_r cleared", led, 16'h0000);

      // SHIFT -> FLASH, then one flash cycle.
      mode = 2'b00; pulse("to_shift");
      mode = 2'b10; pulse("to_flash");
      chk("flash entry", led, 16'h0000);
      pulse("flash on");
      chk("flash on val", led, 16'hFFFF);
      pulse("flash off");

      // Mode 11 with dir toggling every step.
      mode = 2'b11; dir = 1'b0;
      pulse("m11 entry");
      for (int i = 0; i < 30; i++) begin
         dir = ~dir;
         pulse("m11 run");
`ifdef LED_SHIFTER_BOUNCE_EN
         if (i == 14) chk("bounce top", led, 16'h8000);
         if (i == 15) chk("bounce turn", led, 16'h4000);
`endif
      end
      mode = 2'b00; dir = 1'b0;
      pulse("m11 to 00");

      // Disabled: ticks ignored.
      held = m_led;
      en = 1'b0;
      for (int i = 0; i < 5; i++) pulse("en0");
      chk("en0 hold", led, held);

      // Tick held high for 10 clk gives a single step.
      en = 1'b1;
      model_step();
      tick = 1'b1;
      @(negedge clk);
      e = sb_q.pop_front();
      chk("held first", led, e.led);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         chk("held led", led, m_led);
         chk("held wrap", {15'b0, wrap}, 16'h0000);
      end
      tick = 1'b0;
      @(negedge clk);

      // Tick already high at reset release must not step.
      tick = 1'b1;
      #2 rst = 1'b0;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("release high", led, 16'h0001);
      end
      tick = 1'b0;
      @(negedge clk);
      mode = 2'b00; dir = 1'b0;
      pulse("post release");
      chk("post release val", led, 16'h0002);

      // Reset in the middle of a fill.
      mode = 2'b01; dir = 1'b0;
      for (int i = 0; i < 9; i++) pulse("fill_l");
      chk("fill_l 00FF", led, 16'h00FF);
      #2 rst = 1'b0;
      #1;
      chk("mid rst led", led, 16'h0001);
      chk("mid rst wrap", {15'b0, wrap}, 16'h0000);
      model_reset();
      @(negedge clk);
      chk("mid rst wrap hold", {15'b0, wrap}, 16'h0000);
      rst = 1'b1;
      @(negedge clk);
      mode = 2'b00; dir = 1'b0;
      pulse("after rst");
      pulse("after rst");
      chk("after rst state", led, 16'h0004);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/led_shifter.md
LED_SHIFTER -- requirements
Module: led_shifter

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-low
- tick  input  1  divided-clock pulse from the upstream clock divider, synchronous to clk
- en  input  1  1 = pattern advances; 0 = hold
- dir  input  1  0 = left (toward bit 15); 1 = right (toward bit 0)
- mode  input  2  00 SHIFT, 01 FILL, 10 FLASH, 11 BOUNCE
- led  output  16  registered LED pattern
- wrap  output  1  one-cycle pulse when the pattern completes a cycle
REQ-002 The block SHALL use no clock other than clk; tick SHALL be treated as data only.

Function
REQ-003 A step event SHALL be defined as tick=1 AND tick_q=0, where tick_q is tick registered on clk.
REQ-004 led and wrap SHALL update one clk after the step event and SHALL change only on step events.
REQ-005 With en=0, step events SHALL be ignored, led SHALL hold, and wrap SHALL be 0.
REQ-006 State register states SHALL be S_SHIFT, S_FILL, S_FLASH and S_BOUNCE, one per mode code.
REQ-007 On a step with en=1 and mode differing from the current state:
- state SHALL move to the new mode
- led SHALL load the init pattern: SHIFT/BOUNCE 16'h0001; FILL/FLASH 16'h0000
- no shift SHALL occur and wrap SHALL be 0
REQ-008 S_SHIFT: led SHALL rotate one position in dir; wrap=1 when the set bit moves 15->0 (left) or 0->15 (right).
REQ-009 S_FILL: led SHALL shift in dir, inserting a 1 at bit 0 (left) or bit 15 (right).
- From 16'hFFFF the next step SHALL clear led to 0 with wrap=1.
REQ-010 S_FLASH: led SHALL toggle between 16'h0000 and 16'hFFFF; wrap=1 on each transition to 0.
REQ-011 S_BOUNCE: the one-hot bit SHALL move in an internal direction bdir.
- bdir SHALL load from dir on entry to the state.
- At bit 15 (moving left) or bit 0 (moving right), bdir SHALL invert and the bit SHALL move one place back, with wrap=1.
- dir SHALL be ignored while in S_BOUNCE.
REQ-012 A dir change in S_SHIFT or S_FILL SHALL apply at the next step with no reload.
REQ-013 If led is not a legal pattern for the state (e.g. zero in SHIFT), the next step SHALL load the init pattern.
REQ-014 wrap SHALL be high for exactly one clk per wrap event.

Reset
REQ-015 rst=0 SHALL asynchronously set: led=16'h0001, state=S_SHIFT, wrap=0, tick_q=0, bdir=left.
REQ-016 The first step after rst deasserts SHALL require a fresh tick rising edge; a tick already high at release SHALL not step.
REQ-017 Reset asserted mid-pattern SHALL abandon the pattern with no wrap pulse.

Configuration
REQ-018 Macro LED_SHIFTER_BOUNCE_EN:
- Defined: BOUNCE behaves per REQ-011.
- Undefined: mode 11 SHALL behave as SHIFT, no S_BOUNCE state or bdir register SHALL exist, and mode 11<->00 changes SHALL not reload.

Structure
REQ-019 Package led_shifter_pkg SHALL hold LED_W=16, the state enum, the mode codes and the init patterns.
REQ-020 Step detection SHALL be the sub-module tick_edge_detect (clk, rst, tick -> step).

Verification
REQ-021 Reset, mode=00, dir=0, en=1, 16 ticks -> led 0001,0002,...,8000,0001; wrap pulses once, on 8000->0001.
REQ-022 mode=01, dir=1, 17 ticks -> 8000,C000,...,FFFF then 0000 with wrap=1.
REQ-023 mode=00 to 10 with a tick -> led=0000, no wrap; next two ticks -> FFFF, then 0000 with wrap=1.
REQ-024 BOUNCE with macro defined, dir=0, 30 ticks from 0001 -> reaches 8000, reverses to 4000, wrap=1 at the turn; dir toggles have no effect.
REQ-025 en=0 for 5 ticks -> led constant, wrap=0; tick held high 10 clk -> exactly one step.
REQ-026 rst asserted mid-FILL at 00FF -> led=0001 immediately, state S_SHIFT, wrap=0.
